// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Round-robin arbiter sharing the register file write port among
//            NREQ writeback sources, with registered write port and a
//            saturating conflict counter.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int CW   = 16
) (
    input  logic                 reg_clk,
    input  logic                 reg_rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [5*NREQ-1:0]    req_addr,
    input  logic [32*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 regwrite,
    output logic [4:0]           write_3,
    output logic [31:0]          write_data_p3,
    output logic [CW-1:0]        conflict_cnt,
    output logic [NREQ-1:0]      last_grant
);

    localparam int c_PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [c_PTR_W-1:0] r_ptr;
    logic               r_regwrite;
    logic [4:0]         r_write_addr;
    logic [31:0]        r_write_data;
    logic [CW-1:0]      r_conflict_cnt;
    logic [NREQ-1:0]    r_last_grant;

    logic               w_found;
    logic [c_PTR_W-1:0] w_sel;
    logic [c_PTR_W-1:0] w_pos;
    int                 w_slot;
    logic [NREQ-1:0]    w_grant;
    logic               w_any;
    logic [4:0]         w_addr;
    logic [31:0]        w_data;
    logic [c_PTR_W-1:0] w_ptr_nxt;
    logic               w_conflict;
    logic               w_cnt_sat;

    // Scan requesters in priority order ptr, ptr+1, ... (mod NREQ); first valid wins.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_pos   = '0;
        w_slot  = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_slot = (int'(r_ptr) + k) % NREQ;
            w_pos  = w_slot[c_PTR_W-1:0];
            if (!w_found && req_valid[w_pos]) begin
                w_found = 1'b1;
                w_sel   = w_pos;
            end
        end
    end

    always_comb begin
        w_grant = '0;
        if (w_found && !reg_rst) begin
            w_grant[w_sel] = 1'b1;
        end
    end

    // Select the winner's payload and the pointer value that follows it.
    always_comb begin
        w_addr    = '0;
        w_data    = '0;
        w_ptr_nxt = r_ptr;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_addr    = req_addr[5*i +: 5];
                w_data    = req_data[32*i +: 32];
                w_ptr_nxt = (i == NREQ - 1) ? '0 : c_PTR_W'(i + 1);
            end
        end
    end

    assign w_any      = |w_grant;
    assign w_conflict = ($countones(req_valid) >= 2);
    assign w_cnt_sat  = (r_conflict_cnt == {CW{1'b1}});

    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            r_ptr          <= '0;
            r_regwrite     <= 1'b0;
            r_write_addr   <= '0;
            r_write_data   <= '0;
            r_last_grant   <= '0;
            r_conflict_cnt <= '0;
        end else begin
            // Register 0 writes are acknowledged but never enabled on the port.
            r_regwrite <= w_any && (w_addr != 5'd0);
            if (w_any) begin
                r_write_addr <= w_addr;
                r_write_data <= w_data;
                r_last_grant <= w_grant;
                r_ptr        <= w_ptr_nxt;
            end
            if (w_conflict && !w_cnt_sat) begin
                r_conflict_cnt <= r_conflict_cnt + 1'b1;
            end
        end
    end

    assign req_ready     = w_grant;
    assign regwrite      = r_regwrite;
    assign write_3       = r_write_addr;
    assign write_data_p3 = r_write_data;
    assign conflict_cnt  = r_conflict_cnt;
    assign last_grant    = r_last_grant;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Directed and randomized self-checking bench for regfile_wb_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int N   = 3;
    localparam int CWT = 4;

    logic               reg_clk = 1'b0;
    logic               reg_rst = 1'b1;
    logic [N-1:0]       req_valid = '0;
    logic [5*N-1:0]     req_addr  = '0;
    logic [32*N-1:0]    req_data  = '0;
    logic [N-1:0]       req_ready;
    logic               regwrite;
    logic [4:0]         write_3;
    logic [31:0]        write_data_p3;
    logic [CWT-1:0]     conflict_cnt;
    logic [N-1:0]       last_grant;

    regfile_wb_arbiter #(.NREQ(N), .CW(CWT)) dut (
        .reg_clk       (reg_clk),
        .reg_rst       (reg_rst),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .regwrite      (regwrite),
        .write_3       (write_3),
        .write_data_p3 (write_data_p3),
        .conflict_cnt  (conflict_cnt),
        .last_grant    (last_grant)
    );

    always #5 reg_clk = ~reg_clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          m_ptr = 0;
    logic        m_rw  = 1'b0;
    logic [4:0]  m_w3  = '0;
    logic [31:0] m_wd  = '0;
    logic [N-1:0] m_lg = '0;
    int          m_cnt = 0;
    int          last_g = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int p);
        int idx;
        for (int k = 0; k < N; k++) begin
            idx = (p + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
        req_valid[i]        = v;
        req_addr[5*i +: 5]  = a;
        req_data[32*i +: 32] = d;
    endtask

    // One clock: check grant before the edge, advance the model, check registers after.
    task automatic cycle();
        int g;
        int nv;
        @(negedge reg_clk);
        g  = reg_rst ? -1 : pick(req_valid, m_ptr);
        chk("req_ready", {29'd0, req_ready}, (g < 0) ? 32'd0 : (32'd1 << g));
        nv = $countones(req_valid);
        @(posedge reg_clk);
        #1;
        if (reg_rst) begin
            m_ptr = 0; m_rw = 1'b0; m_w3 = '0; m_wd = '0; m_lg = '0; m_cnt = 0;
        end else begin
            if (g >= 0) begin
                m_w3  = req_addr[5*g +: 5];
                m_wd  = req_data[32*g +: 32];
                m_rw  = (m_w3 != 5'd0);
                m_lg  = N'(1 << g);
                m_ptr = (g + 1) % N;
            end else begin
                m_rw = 1'b0;
            end
            if (nv >= 2 && m_cnt < (1 << CWT) - 1) m_cnt++;
        end
        last_g = g;
        chk("regwrite", {31'd0, regwrite}, {31'd0, m_rw});
        chk("write_3", {27'd0, write_3}, {27'd0, m_w3});
        chk("write_data_p3", write_data_p3, m_wd);
        chk("last_grant", {29'd0, last_grant}, {29'd0, m_lg});
        chk("conflict_cnt", {28'd0, conflict_cnt}, m_cnt);
    endtask

    initial begin
        int exp_seq[6] = '{0, 1, 2, 0, 1, 2};
        int found;

        // Reset held two cycles with every requester valid
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 5'(i + 1), $urandom);
        reg_rst = 1'b1;
        cycle();
        cycle();
        chk("rst_ready", {29'd0, req_ready}, 32'd0);
        chk("rst_cnt", {28'd0, conflict_cnt}, 32'd0);
        reg_rst = 1'b0;

        // Round-robin: acknowledged requester drops for one cycle then returns
        for (int c = 0; c < 6; c++) begin
            cycle();
            chk("rr_seq", last_g, exp_seq[c]);
            for (int i = 0; i < N; i++) begin
                if (i == last_g) req_valid[i] = 1'b0;
                else if (!req_valid[i]) set_req(i, 1'b1, 5'($urandom_range(1, 31)), $urandom);
            end
        end
        chk("rr_cnt", {28'd0, conflict_cnt}, 32'd6);

        // Single request from requester 1
        req_valid = '0;
        set_req(1, 1'b1, 5'd5, 32'hDEADBEEF);
        cycle();
        chk("single_grant", last_g, 1);
        chk("single_rw", {31'd0, regwrite}, 32'd1);
        chk("single_addr", {27'd0, write_3}, 32'd5);
        chk("single_data", write_data_p3, 32'hDEADBEEF);
        req_valid = '0;
        cycle();
        chk("single_rw_off", {31'd0, regwrite}, 32'd0);

        // Write to register 0 is acknowledged but not enabled
        set_req(2, 1'b1, 5'd0, 32'h12345678);
        cycle();
        chk("r0_grant", last_g, 2);
        chk("r0_rw", {31'd0, regwrite}, 32'd0);
        chk("r0_last_grant", {29'd0, last_grant}, 32'h4);
        chk("r0_data", write_data_p3, 32'h12345678);
        req_valid = '0;

        // Saturation: two requesters continuously valid
        set_req(0, 1'b1, 5'($urandom_range(0, 31)), $urandom);
        set_req(1, 1'b1, 5'($urandom_range(0, 31)), $urandom);
        for (int c = 0; c < 20; c++) begin
            cycle();
            if (last_g >= 0) set_req(last_g, 1'b1, 5'($urandom_range(0, 31)), $urandom);
        end
        chk("sat_cnt", {28'd0, conflict_cnt}, 32'd15);
        cycle();
        chk("sat_hold", {28'd0, conflict_cnt}, 32'd15);

        // Mid-operation reset right after requester 0 is granted
        req_valid = '0;
        set_req(0, 1'b1, 5'd7, $urandom);
        set_req(2, 1'b1, 5'd9, $urandom);
        found = 0;
        for (int c = 0; c < 4 && found == 0; c++) begin
            cycle();
            if (last_g == 0) found = 1;
            else if (last_g >= 0) set_req(last_g, 1'b1, 5'd9, $urandom);
        end
        chk("mid_grant0", found, 1);
        chk("mid_inflight", {31'd0, regwrite}, 32'd1);
        set_req(0, 1'b1, 5'd3, $urandom);
        reg_rst = 1'b1;
        cycle();
        chk("mid_rw_clr", {31'd0, regwrite}, 32'd0);
        reg_rst = 1'b0;
        cycle();
        chk("mid_ptr0", last_g, 0);

        // Randomized traffic with occasional reset
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || i == last_g)
                    set_req(i, ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom);
            end
            reg_rst = ($urandom_range(0, 49) == 0);
            cycle();
        end
        reg_rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port among several writeback sources (ALU, load unit, multiply/divide unit). Each source presents a valid/ready write request; the block grants one per cycle by round-robin and registers the winning write onto the register file write port. Writes to register 0 are consumed but never asserted on the port. A saturating conflict counter supports performance debug.

## Interface
- `NREQ`, default 3: number of writeback requesters; legal range 2..8.
- `CW`, default 16: width of the conflict counter.

Ports:
- `reg_clk` in 1: clock; all state updates on the rising edge.
- `reg_rst` in 1: synchronous, active-high reset.
- `req_valid` in NREQ: bit i means requester i presents a write this cycle.
- `req_addr` in 5*NREQ: destination register for requester i, in bits [5i+4:5i].
- `req_data` in 32*NREQ: write data for requester i, in bits [32i+31:32i].
- `req_ready` out NREQ: one-hot grant; bit i means requester i's write is accepted this cycle.
- `regwrite` out 1: register file write enable; registered.
- `write_3` out 5: register file write address; registered.
- `write_data_p3` out 32: register file write data; registered.
- `conflict_cnt` out CW: number of cycles in which two or more requesters were valid; saturating.
- `last_grant` out NREQ: one-hot index of the most recent grant; registered.

## Operation
- Grant logic is combinational from `req_valid` and the priority pointer `ptr`. The requester with the highest priority among the valid ones wins.
- Priority order is `ptr`, `ptr+1`, …, wrapping modulo NREQ.
- `req_ready` is the one-hot grant vector. It is all zeros when no request is valid and never has more than one bit set.
- A requester is acknowledged only when its `req_valid` and `req_ready` are both 1 in the same cycle.
- Requesters keep `valid`, `addr` and `data` stable until acknowledged. The block does not store ungranted requests.
- Pointer update: on a grant to requester g, `ptr` becomes (g+1) mod NREQ. With no grant, `ptr` holds.
- Output register, updated every cycle:
  - On a grant with address ≠ 0: `regwrite`=1, and `write_3`/`write_data_p3` take the granted address and data.
  - On a grant to address 0: `regwrite`=0. The requester is still acknowledged. `write_3`/`write_data_p3` still update.
  - With no grant: `regwrite`=0, and `write_3`/`write_data_p3` hold.
- `last_grant` loads the grant vector on a grant and holds otherwise.
- `conflict_cnt` increments by 1 in every cycle where popcount(`req_valid`) ≥ 2. It stops at 2^CW−1 and does not wrap.

## Timing
- Reset values, applied on the first rising edge with `reg_rst`=1:
  - `ptr`=0, so requester 0 has top priority.
  - `regwrite`=0, `write_3`=0, `write_data_p3`=0.
  - `last_grant`=0, `conflict_cnt`=0.
- While `reg_rst`=1:
  - `req_ready` is forced to 0, so nothing is acknowledged.
  - A request in progress at reset is dropped. The requester must keep it asserted and it is granted after reset releases.
- Latency: a request granted in cycle N drives `regwrite`/`write_3`/`write_data_p3` from the rising edge ending cycle N until the next rising edge.
- The register file samples the port on the falling edge in the middle of that cycle. Outputs are register-driven and therefore stable at that falling edge.
- Throughput: one write per cycle. There is no backpressure from the register file.
- A requester that stays valid is granted within NREQ cycles (no starvation).
- Two requesters with the same destination register in consecutive grants are written in grant order, so the later grant wins.
- Simultaneous events:
  - Pointer update, output load and counter increment all occur on the same edge.
  - Reset overrides all of them.

## Test plan
- **Reset:** hold `reg_rst` 2 cycles with all `req_valid`=1.
  - Required: `req_ready`=000, `regwrite`=0, `write_3`=0, `write_data_p3`=0, `conflict_cnt`=0.
  - Required, first cycle after release: `req_ready`=001.
- **Single request:** requester 1 alone, addr=5, data=0xDEADBEEF, valid for 1 cycle.
  - Required: `req_ready`=010 that cycle.
  - Required, next cycle: `regwrite`=1, `write_3`=5, `write_data_p3`=0xDEADBEEF.
  - Required, following cycle: `regwrite`=0.
- **Round-robin:** all three requesters valid continuously for 6 cycles after reset, each dropping valid once acknowledged and re-asserting the next cycle.
  - Required grant sequence: 0,1,2,0,1,2.
  - Required: `conflict_cnt` ≥ 4 at the end, one increment per cycle with two or more valid.
- **Register 0 write:** requester 2 alone, addr=0, data=0x12345678.
  - Required: `req_ready`=100, `regwrite` stays 0 the next cycle, `last_grant`=100.
- **Saturation:** with CW=4, two requesters valid for 20 cycles.
  - Required: `conflict_cnt` reaches 15 and holds at 15.
- **Mid-operation reset:** requesters 0 and 2 valid, assert reset for one cycle after requester 0 is granted.
  - Required: `ptr` returns to 0 and the write in flight is cleared (`regwrite`=0 after reset).
  - Required, first cycle after release: `req_ready`=001, because requester 0 has top priority again.
